// File: rtl/flexbus_reg_arbiter.sv
// rtl/flexbus_reg_arbiter.sv - FlexBus slave register bank with host-priority local access port
// Optional error counter build: define FB_ERR_CNT_EN.
module flexbus_reg_arbiter #(
  parameter logic [31:0] FB_BASE   = 32'h6000_0000,
  parameter logic [31:0] ADDR_MASK = 32'h0000_001F,
  parameter int          NUM_REGS  = 8,
  parameter int          TIMEOUT   = 16
) (
  input  logic                    FB_CLK,
  input  logic                    RST_n,
  input  logic                    FB_ALE,
  input  logic                    FB_CS,
  input  logic                    FB_RW,
  input  logic [31:0]             FB_AD_I,
  output logic [31:0]             FB_AD_O,
  output logic                    FB_AD_OE,
  input  logic                    LOC_REQ,
  input  logic                    LOC_WE,
  input  logic [2:0]              LOC_ADDR,
  input  logic [31:0]             LOC_WDATA,
  output logic                    LOC_ACK,
  output logic [31:0]             LOC_RDATA,
  output logic [32*NUM_REGS-1:0]  REGS_Qout
`ifdef FB_ERR_CNT_EN
  ,
  output logic [15:0]             ERR_CNT
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]  NR      = 4'(NUM_REGS);

  logic [31:0]   regs_q [NUM_REGS];
  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          rw_q, rw_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          oe_q, oe_d;
  logic [31:0]   ado_q, ado_d;
  logic          loc_ack_q;
  logic [31:0]   loc_rdata_q;

  logic [2:0]    ale_idx;
  logic          ale_hit;
  logic [31:0]   ale_rdata;
  logic          host_we;
  logic          host_reg_we;
  logic          err_evt;
  logic          loc_valid;
  logic          loc_accept;

  assign ale_idx    = FB_AD_I[4:2];
  assign ale_hit    = ((FB_AD_I & ~ADDR_MASK) == FB_BASE) && ({1'b0, ale_idx} < NR);
  assign loc_valid  = {1'b0, LOC_ADDR} < NR;
  // A local access may only slip into a bus-idle cycle; the ack bubble blocks a re-accept.
  assign loc_accept = (state_q == S_IDLE) && !FB_ALE && LOC_REQ && !loc_ack_q;

`ifdef FB_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic        err_clr;
  assign err_clr     = host_we && ({1'b0, idx_q} == NR - 4'd1);
  assign host_reg_we = host_we && !err_clr;
  assign ERR_CNT     = err_cnt_q;
`else
  assign host_reg_we = host_we;
`endif

  always_comb begin
    ale_rdata = regs_q[ale_idx];
`ifdef FB_ERR_CNT_EN
    if ({1'b0, ale_idx} == NR - 4'd1) ale_rdata = {16'd0, err_cnt_q};
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    oe_d    = oe_q;
    ado_d   = ado_q;
    host_we = 1'b0;
    err_evt = 1'b0;
    if (FB_ALE) begin
      // New address phase always restarts decode, aborting anything in flight.
      err_evt = (state_q != S_IDLE);
      cnt_d   = '0;
      idx_d   = ale_idx;
      rw_d    = FB_RW;
      if (ale_hit) begin
        state_d = S_ADDR;
        oe_d    = FB_RW;
        ado_d   = FB_RW ? ale_rdata : 32'd0;
      end else begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
        ado_d   = 32'd0;
        err_evt = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (!FB_CS) begin
            state_d = S_DATA;
            cnt_d   = '0;
            host_we = !rw_q;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            ado_d   = 32'd0;
            err_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (FB_CS) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            ado_d   = 32'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          ado_d   = 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge FB_CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rw_q        <= 1'b0;
      cnt_q       <= '0;
      oe_q        <= 1'b0;
      ado_q       <= '0;
      loc_ack_q   <= 1'b0;
      loc_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      oe_q      <= oe_d;
      ado_q     <= ado_d;
      loc_ack_q <= loc_accept;
      if (loc_accept && !LOC_WE) loc_rdata_q <= loc_valid ? regs_q[LOC_ADDR] : 32'd0;
    end
  end

  // Host and local writes are mutually exclusive: local accept requires IDLE and no ALE.
  always_ff @(posedge FB_CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (host_reg_we) begin
      regs_q[idx_q] <= FB_AD_I;
    end else if (loc_accept && LOC_WE && loc_valid) begin
      regs_q[LOC_ADDR] <= LOC_WDATA;
    end
  end

`ifdef FB_ERR_CNT_EN
  always_ff @(posedge FB_CLK or negedge RST_n) begin
    if (!RST_n) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (err_evt && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign REGS_Qout[32*g +: 32] = regs_q[g];
  end

  assign FB_AD_O   = ado_q;
  assign FB_AD_OE  = oe_q;
  assign LOC_ACK   = loc_ack_q;
  assign LOC_RDATA = loc_rdata_q;

endmodule

// File: tb/tb_flexbus_reg_arbiter.sv
// tb/tb_flexbus_reg_arbiter.sv - scoreboard bench for flexbus_reg_arbiter
module tb_flexbus_reg_arbiter;

  localparam int NREG = 8;
  localparam int TO   = 16;

  logic               FB_CLK = 1'b0;
  logic               RST_n;
  logic               FB_ALE, FB_CS, FB_RW;
  logic [31:0]        FB_AD_I;
  logic [31:0]        FB_AD_O;
  logic               FB_AD_OE;
  logic               LOC_REQ, LOC_WE;
  logic [2:0]         LOC_ADDR;
  logic [31:0]        LOC_WDATA;
  logic               LOC_ACK;
  logic [31:0]        LOC_RDATA;
  logic [32*NREG-1:0] REGS_Qout;
`ifdef FB_ERR_CNT_EN
  logic [15:0]        ERR_CNT;
`endif

  flexbus_reg_arbiter #(
    .FB_BASE(32'h6000_0000), .ADDR_MASK(32'h0000_001F), .NUM_REGS(NREG), .TIMEOUT(TO)
  ) dut (
    .FB_CLK(FB_CLK), .RST_n(RST_n), .FB_ALE(FB_ALE), .FB_CS(FB_CS), .FB_RW(FB_RW),
    .FB_AD_I(FB_AD_I), .FB_AD_O(FB_AD_O), .FB_AD_OE(FB_AD_OE),
    .LOC_REQ(LOC_REQ), .LOC_WE(LOC_WE), .LOC_ADDR(LOC_ADDR), .LOC_WDATA(LOC_WDATA),
    .LOC_ACK(LOC_ACK), .LOC_RDATA(LOC_RDATA), .REGS_Qout(REGS_Qout)
`ifdef FB_ERR_CNT_EN
    , .ERR_CNT(ERR_CNT)
`endif
  );

  always #5 FB_CLK = ~FB_CLK;

  typedef struct {
    bit          is_loc;
    bit          chk_val;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [NREG];
  logic        oe_prev = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void sb_pop(bit is_loc, logic [31:0] act, string name);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected response %h, got nothing expected", name, act);
      return;
    end
    e = sb.pop_front();
    if (e.is_loc != is_loc) begin
      n_fail++;
      $display("FAIL %s: response kind got loc=%0d expected loc=%0d", name, is_loc, e.is_loc);
    end else if (e.chk_val && act !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, e.val);
    end
  endfunction

  // Monitor: any ack or rising read-enable must match the head of the scoreboard.
  always @(negedge FB_CLK) begin
    if (LOC_ACK) sb_pop(1'b1, LOC_RDATA, "loc_ack");
    if (FB_AD_OE && !oe_prev) sb_pop(1'b0, FB_AD_O, "host_rd");
    oe_prev = FB_AD_OE;
  end

  task automatic tick();
    @(posedge FB_CLK);
    #1;
  endtask

  task automatic push(bit is_loc, bit chk_val, logic [31:0] val);
    exp_t e;
    e.is_loc = is_loc; e.chk_val = chk_val; e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_regs(string name);
    for (int i = 0; i < NREG; i++) chk($sformatf("%s_reg%0d", name, i), REGS_Qout[32*i +: 32], model[i]);
  endtask

  task automatic host_write(logic [31:0] addr, logic [31:0] data);
    FB_ALE = 1'b1; FB_AD_I = addr; FB_RW = 1'b0;
    tick();
    FB_ALE = 1'b0; FB_CS = 1'b0; FB_AD_I = data;
    tick();
    chk("wr_oe_data", {31'd0, FB_AD_OE}, 32'd0);
    FB_CS = 1'b1;
    tick();
  endtask

  task automatic host_read(logic [31:0] addr, logic [31:0] exp);
    FB_ALE = 1'b1; FB_AD_I = addr; FB_RW = 1'b1;
    push(1'b0, 1'b1, exp);
    tick();
    FB_ALE = 1'b0; FB_AD_I = 32'd0;
    chk("rd_oe_lat1", {31'd0, FB_AD_OE}, 32'd1);
    FB_CS = 1'b0;
    tick();
    tick();
    chk("rd_hold", FB_AD_O, exp);
    FB_CS = 1'b1;
    tick();
    chk("rd_oe_drop", {31'd0, FB_AD_OE}, 32'd0);
  endtask

  initial begin
    RST_n = 1'b0; FB_ALE = 1'b0; FB_CS = 1'b1; FB_RW = 1'b0; FB_AD_I = '0;
    LOC_REQ = 1'b0; LOC_WE = 1'b0; LOC_ADDR = '0; LOC_WDATA = '0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    tick(); tick();
    chk("rst_oe", {31'd0, FB_AD_OE}, 32'd0);
    chk("rst_ado", FB_AD_O, 32'd0);
    chk("rst_ack", {31'd0, LOC_ACK}, 32'd0);
    chk("rst_lrd", LOC_RDATA, 32'd0);
    check_regs("rst");
    RST_n = 1'b1;
    tick();

    host_write(32'h6000_0000, 32'd1000); model[0] = 32'd1000;
    check_regs("wr0");

    host_write(32'h6000_0004, 32'd2000); model[1] = 32'd2000;
    host_read(32'h6000_0004, 32'd2000);
    check_regs("wr1");

    // Base-address miss, then an unmasked-bit miss just above the window.
    host_write(32'h7000_0000, 32'd5);
`ifdef FB_ERR_CNT_EN
    chk("err_cnt_miss", {16'd0, ERR_CNT}, 32'd1);
`endif
    host_write(32'h6000_0020, 32'd6);
    host_write(32'h6000_001C, 32'h77); model[7] = 32'h77;
    check_regs("miss");

    // Local write collides with ALE; host read of reg2 wins and sees the old value.
    LOC_REQ = 1'b1; LOC_WE = 1'b1; LOC_ADDR = 3'd2; LOC_WDATA = 32'hA5A5;
    FB_ALE = 1'b1; FB_AD_I = 32'h6000_0008; FB_RW = 1'b1;
    push(1'b0, 1'b1, 32'd0);
    tick();
    chk("coll_no_ack", {31'd0, LOC_ACK}, 32'd0);
    FB_ALE = 1'b0; FB_CS = 1'b0;
    tick();
    chk("coll_no_ack_data", {31'd0, LOC_ACK}, 32'd0);
    FB_CS = 1'b1;
    tick();
    chk("coll_reg2_old", REGS_Qout[64 +: 32], 32'd0);
    chk("coll_no_ack_idle", {31'd0, LOC_ACK}, 32'd0);
    push(1'b1, 1'b0, 32'd0);
    tick();
    model[2] = 32'hA5A5;
    chk("loc_ack_pulse", {31'd0, LOC_ACK}, 32'd1);
    LOC_REQ = 1'b0;
    tick();
    chk("loc_ack_low", {31'd0, LOC_ACK}, 32'd0);
    check_regs("locwr");

    // Local read held across the ack cycle must only be accepted once.
    LOC_REQ = 1'b1; LOC_WE = 1'b0; LOC_ADDR = 3'd2;
    push(1'b1, 1'b1, 32'hA5A5);
    tick(); tick();
    chk("bubble_ack_low", {31'd0, LOC_ACK}, 32'd0);
    LOC_REQ = 1'b0;
    tick();
    host_read(32'h6000_0008, 32'hA5A5);

    // TIMEOUT-1 high cycles still allows the write; TIMEOUT cycles aborts it.
    FB_ALE = 1'b1; FB_AD_I = 32'h6000_000C; FB_RW = 1'b0;
    tick();
    FB_ALE = 1'b0; FB_AD_I = 32'hDEAD;
    repeat (TO - 1) tick();
    FB_CS = 1'b0; FB_AD_I = 32'h33;
    tick();
    FB_CS = 1'b1;
    tick();
    model[3] = 32'h33;
    FB_ALE = 1'b1; FB_AD_I = 32'h6000_000C; FB_RW = 1'b0;
    tick();
    FB_ALE = 1'b0; FB_AD_I = 32'hDEAD;
    repeat (TO) tick();
    FB_CS = 1'b0; FB_AD_I = 32'h44;
    tick();
    FB_CS = 1'b1;
    tick();
    check_regs("timeout");

    // ALE abort before commit, then multi-beat write commits only the first beat.
    FB_ALE = 1'b1; FB_AD_I = 32'h6000_0010; FB_RW = 1'b0;
    tick();
    FB_AD_I = 32'h6000_0014;
    tick();
    FB_ALE = 1'b0; FB_CS = 1'b0; FB_AD_I = 32'h55;
    tick();
    FB_CS = 1'b1;
    tick();
    model[5] = 32'h55;
    FB_ALE = 1'b1; FB_AD_I = 32'h6000_0018; FB_RW = 1'b0;
    tick();
    FB_ALE = 1'b0; FB_CS = 1'b0; FB_AD_I = 32'h11;
    tick();
    FB_AD_I = 32'h22;
    tick();
    FB_AD_I = 32'h33;
    tick();
    FB_CS = 1'b1;
    tick();
    model[6] = 32'h11;
    check_regs("abort_beats");

    // Asynchronous reset in the middle of a read data phase.
    FB_ALE = 1'b1; FB_AD_I = 32'h6000_0000; FB_RW = 1'b1;
    push(1'b0, 1'b1, 32'd1000);
    tick();
    FB_ALE = 1'b0; FB_CS = 1'b0;
    tick();
    #2;
    RST_n = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    chk("arst_oe", {31'd0, FB_AD_OE}, 32'd0);
    chk("arst_ado", FB_AD_O, 32'd0);
    check_regs("arst");
    FB_CS = 1'b1;
    tick();
    RST_n = 1'b1;
    LOC_REQ = 1'b1; LOC_WE = 1'b0; LOC_ADDR = 3'd0;
    push(1'b1, 1'b1, 32'd0);
    tick();
    chk("arst_idle_accept", {31'd0, LOC_ACK}, 32'd1);
    LOC_REQ = 1'b0;
    tick(); tick();

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flexbus_reg_arbiter.md
Name: flexbus_reg_arbiter

Overview:
- FlexBus slave front end that owns a shared bank of NUM_REGS 32-bit control registers (LED/buzzer frequency and duty values).
- Decodes the multiplexed FB_AD address/data phases from the MCU.
- Arbitrates register access between the FlexBus host and one PL-side local requester.
- The host always wins, because FlexBus has no wait-state in this design. Register contents feed the PWM/frequency generators.

Parameters:
- FB_BASE, 32'h60000000, base address of the register bank.
- ADDR_MASK, 32'h0000001F, address bits ignored by the hit compare. Hit when (addr & ~ADDR_MASK) == FB_BASE.
- NUM_REGS, 8, number of registers. Index = addr[4:2]; indices >= NUM_REGS are misses.
- TIMEOUT, 16, idle cycles allowed between the address phase and CS assertion before abort.

Ports:
- FB_CLK  in  1  single clock.
- RST_n  in  1  asynchronous active-low reset.
- FB_ALE  in  1  address latch enable, active high.
- FB_CS  in  1  chip select, active low.
- FB_RW  in  1  1 = read, 0 = write.
- FB_AD_I  in  32  multiplexed address/data in.
- FB_AD_O  out  32  read data to pad.
- FB_AD_OE  out  1  pad output enable; the top level builds the tristate.
- LOC_REQ  in  1  local access request, held until LOC_ACK.
- LOC_WE  in  1  local write enable.
- LOC_ADDR  in  3  local register index.
- LOC_WDATA  in  32  local write data.
- LOC_ACK  out  1  one-cycle completion pulse.
- LOC_RDATA  out  32  local read data, valid with LOC_ACK.
- REGS_Qout  out  32*NUM_REGS  flattened register contents; reg i sits at [32i+31:32i].

Behaviour:
- Reset (RST_n low, asynchronous): state IDLE, all registers 0, FB_AD_O=0, FB_AD_OE=0, LOC_ACK=0, LOC_RDATA=0, timeout counter 0.
- States: IDLE, ADDR, DATA.
- IDLE, FB_ALE=1 sampled: latch the address index and FB_RW.
  - Hit: go to ADDR.
  - Miss: stay in IDLE and ignore the rest of the cycle group; the bus is never driven.
- ADDR:
  - FB_AD_OE=1 if the latched RW=1; FB_AD_O = reg[idx], registered at the ALE edge.
  - FB_CS=0 sampled: go to DATA.
  - Write: commit FB_AD_I into reg[idx] on that same edge.
  - Counter increments each cycle CS stays high; reaching TIMEOUT returns to IDLE with OE=0 and no write.
- DATA:
  - Remain while CS=0. Only the first CS-low edge commits a write; later beats are ignored.
  - CS=1 sampled: return to IDLE; OE drops the same edge.
- FB_ALE=1 sampled in ADDR or DATA: abort the current transfer (no write if it has not committed yet) and restart decode with the new address.
- Read latency: data is on FB_AD_O one cycle after the ALE edge and held until CS is released.
- Local accept edge requires all of: state IDLE, FB_ALE=0, LOC_REQ=1, LOC_ACK=0.
  - Write: commit LOC_WDATA on the accept edge.
  - Read: capture reg[LOC_ADDR] into LOC_RDATA.
  - LOC_ACK is high for exactly the next cycle. The mandatory bubble prevents a double accept.
- LOC_ADDR >= NUM_REGS: acked; write dropped, read returns 0.
- ALE and local request in the same cycle: FlexBus wins; local waits until IDLE with no ALE.
- No local starvation bound beyond the bus idle gap; the MCU guarantees gaps.
- Host write and local write never share an edge, because a local accept needs IDLE and no ALE.
- Host read after a local write to the same register: returns the new value.

Optional Feature:
- Macro FB_ERR_CNT_EN.
- When defined:
  - Adds output port ERR_CNT (16 bits, reset 0).
  - Increments once per address-phase miss, timeout or ALE abort; saturates at 16'hFFFF.
  - Readable by the host at index NUM_REGS-1 instead of that register; writes to that index clear it.
- When undefined: no port, no counter; index NUM_REGS-1 is a normal register.

Test Plan:
- Write FB_BASE+0: ALE with 0x60000000, then CS low with AD=1000, then CS high -> reg0=1000 on the CS-low edge; OE stays 0 throughout.
- Write 2000 to 0x60000004, then read 0x60000004 -> FB_AD_OE=1 one cycle after ALE; FB_AD_O=2000 until CS is sampled high; then OE=0.
- ALE with 0x70000000 followed by a CS-low write of 5 -> no register changes, OE never asserted; with FB_ERR_CNT_EN, ERR_CNT=1.
- LOC_REQ/LOC_WE for index 2 with 0xA5A5, asserted in the same cycle as FB_ALE -> no accept that cycle; accept once IDLE with ALE low; LOC_ACK pulses one cycle later; reg2=0xA5A5.
- ALE hit, then CS held high for TIMEOUT cycles -> return to IDLE; a following CS-low carries no write.
- RST_n low during DATA of a read -> OE and all registers 0 immediately; state IDLE.
